// File: rtl/vga_timing_pkg.sv
// Shared raster constants: default 640x480@60 timing, sync polarities, coordinate width.
// Pure definitions; no logic, latency or flow control of its own.
package vga_timing_pkg;

    localparam int COORD_W = 12;
    localparam int MAX_TOTAL = 1 << COORD_W;

    localparam bit ACTIVE_LOW  = 1'b0;
    localparam bit ACTIVE_HIGH = 1'b1;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_SYNC_DLY = 2;

    // Bit order fixed so the delay line can carry this as a plain 3-bit vector.
    typedef struct packed {
        logic vid_active;
        logic vsync;
        logic hsync;
    } sync_t;

endpackage

// File: rtl/vga_sync_delay.sv
// DEPTH-stage 3-bit shift register with synchronous active-low clear to RST_VAL.
// Latency DEPTH cycles (DEPTH=0 is a wire); free-running, no backpressure.
module vga_sync_delay #(
    parameter int         DEPTH   = 2,
    parameter logic [2:0] RST_VAL = 3'b000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] d,
    output logic [2:0] q
);

    if (DEPTH < 0 || DEPTH > 7) begin : g_bad_depth
        $error("vga_sync_delay: DEPTH must be 0..7");
    end

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = clk ^ rst;
        assign q = d;
    end else begin : g_pipe
        logic [2:0] stage [DEPTH];

        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage[i] <= RST_VAL;
                end
            end else begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: scan position, video-active, line/frame strobes, delayed syncs.
// Position outputs 1 cycle after the counters; syncs a further SYNC_DLY cycles; free-running.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = ACTIVE_LOW,
    parameter bit V_POL    = ACTIVE_LOW,
    parameter int SYNC_DLY = DEF_SYNC_DLY
) (
    input  logic               pix_clk,
    input  logic               rst,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               vid_active,
    output logic               vid_active_d,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_timing
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must each be <= 4096");
    end

    // One extra bit so window ends equal to a 4096 total still compare correctly.
    typedef logic [COORD_W:0] coord_ext_t;

    localparam coord_ext_t H_LAST     = coord_ext_t'(H_TOTAL - 1);
    localparam coord_ext_t V_LAST     = coord_ext_t'(V_TOTAL - 1);
    localparam coord_ext_t H_ACT_END  = coord_ext_t'(H_ACTIVE);
    localparam coord_ext_t V_ACT_END  = coord_ext_t'(V_ACTIVE);
    localparam coord_ext_t HS_START   = coord_ext_t'(H_ACTIVE + H_FP);
    localparam coord_ext_t HS_END     = coord_ext_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_ext_t VS_START   = coord_ext_t'(V_ACTIVE + V_FP);
    localparam coord_ext_t VS_END     = coord_ext_t'(V_ACTIVE + V_FP + V_SYNC);

    localparam sync_t SYNC_IDLE = '{vid_active: 1'b0, vsync: ~V_POL, hsync: ~H_POL};

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    coord_ext_t         hx;
    coord_ext_t         vx;
    logic               h_wrap;
    logic               v_wrap;
    logic               active_now;
    logic               frame_now;
    sync_t              sync_u;
    sync_t              sync_q;

    assign hx         = {1'b0, h_cnt};
    assign vx         = {1'b0, v_cnt};
    assign h_wrap     = (hx == H_LAST);
    assign v_wrap     = (vx == V_LAST);
    assign active_now = (hx < H_ACT_END) && (vx < V_ACT_END);
    assign frame_now  = (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge pix_clk) begin
        if (!rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            vid_active  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            sync_u      <= SYNC_IDLE;
        end else begin
            pix_x             <= h_cnt;
            pix_y             <= v_cnt;
            vid_active        <= active_now;
            line_start        <= (h_cnt == '0);
            frame_start       <= frame_now;
            sync_u.vid_active <= active_now;
            sync_u.hsync      <= ((hx >= HS_START) && (hx < HS_END)) ? H_POL : ~H_POL;
            sync_u.vsync      <= ((vx >= VS_START) && (vx < VS_END)) ? V_POL : ~V_POL;
            if (frame_now) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            // Vertical count moves only on the horizontal wrap, so both wrap together at frame end.
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    vga_sync_delay #(
        .DEPTH   (SYNC_DLY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk (pix_clk),
        .rst (rst),
        .d   (sync_u),
        .q   (sync_q)
    );

    assign hsync        = sync_q.hsync;
    assign vsync        = sync_q.vsync;
    assign vid_active_d = sync_q.vid_active;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked cycle by cycle against an
// arithmetic raster model, plus line/frame period and sync-width measurements.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        va;
        logic        vad;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
    } out_t;

    typedef struct packed {
        out_t d0;
        out_t d1;
        out_t d2;
    } exp_t;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        int d;
        bit hp, vp;
    } cfg_t;

    cfg_t c_dflt  = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
    cfg_t c_med   = '{16, 4, 4, 4, 8, 2, 2, 2, 2, 1'b0, 1'b0};
    cfg_t c_small = '{8, 2, 2, 2, 4, 1, 1, 1, 0, 1'b1, 1'b1};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [11:0] d0_x, d0_y, d1_x, d1_y, d2_x, d2_y;
    logic        d0_va, d0_vad, d0_hs, d0_vs, d0_ls, d0_fs;
    logic        d1_va, d1_vad, d1_hs, d1_vs, d1_ls, d1_fs;
    logic        d2_va, d2_vad, d2_hs, d2_vs, d2_ls, d2_fs;
    logic [7:0]  d0_fc, d1_fc, d2_fc;

    vga_timing_gen u_dflt (
        .pix_clk (clk), .rst (rst), .pix_x (d0_x), .pix_y (d0_y),
        .vid_active (d0_va), .vid_active_d (d0_vad), .hsync (d0_hs), .vsync (d0_vs),
        .line_start (d0_ls), .frame_start (d0_fs), .frame_cnt (d0_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (4), .H_SYNC (4), .H_BP (4),
        .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (2),
        .H_POL (1'b0), .V_POL (1'b0), .SYNC_DLY (2)
    ) u_med (
        .pix_clk (clk), .rst (rst), .pix_x (d1_x), .pix_y (d1_y),
        .vid_active (d1_va), .vid_active_d (d1_vad), .hsync (d1_hs), .vsync (d1_vs),
        .line_start (d1_ls), .frame_start (d1_fs), .frame_cnt (d1_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .H_POL (1'b1), .V_POL (1'b1), .SYNC_DLY (0)
    ) u_small (
        .pix_clk (clk), .rst (rst), .pix_x (d2_x), .pix_y (d2_y),
        .vid_active (d2_va), .vid_active_d (d2_vad), .hsync (d2_hs), .vsync (d2_vs),
        .line_start (d2_ls), .frame_start (d2_fs), .frame_cnt (d2_fc)
    );

    out_t o_dflt, o_med, o_small;
    assign o_dflt  = {d0_x, d0_y, d0_va, d0_vad, d0_hs, d0_vs, d0_ls, d0_fs, d0_fc};
    assign o_med   = {d1_x, d1_y, d1_va, d1_vad, d1_hs, d1_vs, d1_ls, d1_fs, d1_fc};
    assign o_small = {d2_x, d2_y, d2_va, d2_vad, d2_hs, d2_vs, d2_ls, d2_fs, d2_fc};

    int   n_pass  = 0;
    int   n_total = 0;
    int   p       = -1;   // raster position index since reset release; -1 while in reset
    exp_t sb_q[$];

    bit   meas_on   = 1'b0;
    int   last_ls   = -1;
    int   line_y    = 0;
    int   va_cnt    = 0;
    int   vs_run    = 0;
    int   last_fs   = -1;
    int   prev_fc   = 0;
    int   wrap_seen = 0;

    // Expected outputs derived from the position index alone.
    function automatic out_t model(input int pos, input cfg_t c);
        out_t o;
        int ht, vt, x, y, q, xq, yq;
        ht = c.ha + c.hfp + c.hsw + c.hbp;
        vt = c.va + c.vfp + c.vsw + c.vbp;
        o  = '0;
        o.hs = ~c.hp;
        o.vs = ~c.vp;
        if (pos < 0) return o;
        x    = pos % ht;
        y    = (pos / ht) % vt;
        o.x  = 12'(x);
        o.y  = 12'(y);
        o.va = (x < c.ha) && (y < c.va);
        o.ls = (x == 0);
        o.fs = (x == 0) && (y == 0);
        o.fc = 8'((pos / (ht * vt) + 1) % 256);
        q = pos - c.d;
        if (q >= 0) begin
            xq    = q % ht;
            yq    = (q / ht) % vt;
            o.vad = (xq < c.ha) && (yq < c.va);
            if (xq >= c.ha + c.hfp && xq < c.ha + c.hfp + c.hsw) o.hs = c.hp;
            if (yq >= c.va + c.vfp && yq < c.va + c.vfp + c.vsw) o.vs = c.vp;
        end
        return o;
    endfunction

    task automatic check_out(input string tag, input out_t obs, input out_t exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s pos=%0d observed=%h expected=%h", tag, p, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic measure();
        if (o_dflt.ls) begin
            if (last_ls >= 0) begin
                check_int("dflt_line_period", p - last_ls, 800);
                if (line_y < 480) check_int("dflt_active_len", va_cnt, 640);
            end
            last_ls = p;
            line_y  = int'(o_dflt.y);
            va_cnt  = 0;
        end
        va_cnt += int'(o_dflt.va);

        if (!o_med.vs) begin
            vs_run++;
        end else if (vs_run > 0) begin
            check_int("med_vsync_len", vs_run, 56);
            vs_run = 0;
        end

        if (o_small.fs) begin
            if (last_fs >= 0) check_int("small_frame_period", p - last_fs, 98);
            last_fs = p;
        end
        if (prev_fc == 255 && int'(o_small.fc) == 0) wrap_seen = 1;
        prev_fc = int'(o_small.fc);
    endtask

    task automatic step(input logic rst_v);
        exp_t e;
        rst = rst_v;
        p   = rst_v ? p + 1 : -1;
        e.d0 = model(p, c_dflt);
        e.d1 = model(p, c_med);
        e.d2 = model(p, c_small);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_out("dflt",  o_dflt,  e.d0);
        check_out("med",   o_med,   e.d1);
        check_out("small", o_small, e.d2);
        if (meas_on) measure();
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0);

        // 25200 cycles: 31+ default lines, 64 medium frames, 257 small frames (frame_cnt wrap).
        meas_on = 1'b1;
        for (int i = 0; i < 25200; i++) step(1'b1);
        meas_on = 1'b0;
        check_int("small_fc_wrap_seen", wrap_seen, 1);

        while (p % 800 != 300) step(1'b1);
        step(1'b0);
        check_int("mid_rst_hsync_inactive", int'(d0_hs), 1);
        for (int i = 0; i < 1200; i++) step(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that drives the scan position and video-active inputs of the character pixel generator, and the VGA sync outputs.
- Produces pix_x, pix_y and vid_active aligned with the pixel generator's address path.
- Produces hsync, vsync and a delayed video-active, each delayed by SYNC_DLY pixel clocks, so they line up with the RGB that emerges after char ROM latency.
- Also provides line/frame strobes and a free-running frame counter for cursor blink and animation.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync width, in lines
- V_BP, 33, vertical back porch, in lines
- H_POL, 0, active level of hsync (0 = active-low)
- V_POL, 0, active level of vsync (0 = active-low)
- SYNC_DLY, 2, pipeline stages on hsync/vsync/vid_active_d; range 0..7

Ports:
- pix_clk  in  1  pixel clock; all logic is on the rising edge
- rst  in  1  synchronous, active-low reset
- pix_x  out  12  current horizontal count, 0..H_TOTAL-1
- pix_y  out  12  current vertical count, 0..V_TOTAL-1
- vid_active  out  1  high when pix_x < H_ACTIVE and pix_y < V_ACTIVE; aligned with pix_x/pix_y
- vid_active_d  out  1  vid_active delayed by SYNC_DLY cycles
- hsync  out  1  horizontal sync, at level H_POL when asserted, delayed by SYNC_DLY
- vsync  out  1  vertical sync, at level V_POL when asserted, delayed by SYNC_DLY
- line_start  out  1  one-cycle pulse while pix_x == 0; aligned with pix_x
- frame_start  out  1  one-cycle pulse while pix_x == 0 and pix_y == 0; aligned with pix_x
- frame_cnt  out  8  count of completed frame starts; wraps 255 -> 0

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Elaboration-time check: H_TOTAL and V_TOTAL must each be <= 4096; violation is an error.
- Internal counters h_cnt and v_cnt are 12 bits wide.
  - h_cnt increments every cycle and wraps H_TOTAL-1 -> 0.
  - v_cnt increments only on h_cnt wrap, and wraps V_TOTAL-1 -> 0 when both counters wrap together.
- All outputs are registered.
  - On each edge with rst=1, the output registers load the decode of the current (h_cnt, v_cnt); the counters then advance.
  - Result: the output shows position n one cycle after the counter holds n.
- Reset (any edge with rst=0, including mid-frame):
  - h_cnt=0, v_cnt=0, pix_x=0, pix_y=0
  - vid_active=0, line_start=0, frame_start=0, frame_cnt=0
  - all delay stages cleared to inactive: hsync=~H_POL, vsync=~V_POL, vid_active_d=0
- First edge with rst=1: pix_x=0, pix_y=0, vid_active=1, line_start=1, frame_start=1, frame_cnt=1.
  - The first post-reset frame start counts, so frame_cnt == number of frame starts since reset, mod 256.
- Undelayed hsync is asserted when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (default 656..751).
- Undelayed vsync is asserted for whole lines when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (default 490..491). It changes on the same cycle as the pix_y change, i.e. at x=0.
- Delay stages:
  - hsync, vsync and vid_active_d each pass through SYNC_DLY register stages.
  - SYNC_DLY=0 means they are combinationally equal to the undelayed registered versions.
  - pix_x, pix_y, vid_active, line_start and frame_start are never delayed.
- Period: exactly H_TOTAL*V_TOTAL cycles between frame_start pulses (default 420000). No dropped or duplicated positions at either wrap.
- Simultaneous wraps: at (H_TOTAL-1, V_TOTAL-1) the next output is (0,0) with line_start=1 and frame_start=1 in the same cycle.
- Reset asserted mid-line: takes effect on the next edge. No partial sync pulse is extended; the delay stages are flushed to inactive.

Decomposition:
- Shared package vga_timing_pkg holds:
  - default 640x480@60 timing constants
  - sync polarity constants ACTIVE_LOW/ACTIVE_HIGH
  - the 12-bit coordinate width constant COORD_W, also used by the pixel generator
- One sub-module, vga_sync_delay: a parameterised SYNC_DLY-deep, 3-bit-wide shift register with synchronous active-low clear to a per-bit reset value.

Test Plan:
- Reset: hold rst=0 for 5 cycles -> pix_x=0, pix_y=0, vid_active=0, hsync=1, vsync=1, vid_active_d=0, frame_cnt=0. First edge after release -> pix_x=0, frame_start=1, frame_cnt=1.
- Horizontal timing, defaults: line_start pulses every 800 cycles. vid_active is high for exactly 640 cycles per active line. hsync goes low 2 cycles after pix_x==656 and returns high 2 cycles after pix_x==752.
- Vertical timing: pix_y steps 0..524 once per 800 cycles. vsync is low for exactly 1600 cycles, starting 2 cycles after (pix_x=0, pix_y=490). vid_active stays 0 for pix_y 480..524.
- Frame wrap: after (799,524) the next cycle is (0,0) with line_start=1 and frame_start=1. frame_start pulses are 420000 cycles apart. Run 256 frames -> frame_cnt wraps from 255 to 0.
- Mid-frame reset: assert rst=0 at (300,200) for 1 cycle -> all outputs take reset values, the delayed syncs are inactive immediately, and the sequence restarts from (0,0) with frame_cnt=1.
- Configuration SYNC_DLY=0, H_POL=1, V_POL=1, small timing (H 8/2/2/2, V 4/1/1/1) -> hsync is high exactly while pix_x is 10..11, with no delay. frame period = 14*7 = 98 cycles.
